// File: rtl/sipo_frame_pkg.sv
// Shared types and defaults for the serial frame receiver.
// Holds the receiver state encoding and the counter-width helper.
package sipo_frame_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int          DEF_N         = 8;
    localparam logic [7:0]  DEF_SYNC_WORD = 8'hA5;
    localparam int          DEF_FRAME_LEN = 4;

    // Counter width for a count of n states; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/word_hold_reg.sv
// Single-entry valid/ready holding register with a drop-on-full overflow pulse.
// A load on the same edge as a consume replaces the held word without loss.
module word_hold_reg #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         accept,
    output logic         overflow
);

    logic room;

    assign accept = out_valid && out_ready;
    assign room   = !out_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= load && !room;
            if (load && room) begin
                out_data  <= load_data;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: hunts for a sync word, then assembles FRAME_LEN
// N-bit words (MSB first) and hands them to a one-entry output register.
module sipo_frame_rx
    import sipo_frame_pkg::*;
#(
    parameter int           N         = DEF_N,
    parameter logic [N-1:0] SYNC_WORD = N'(DEF_SYNC_WORD),
    parameter int           FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         data_in,
    input  logic         bit_en,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         locked,
    output logic         overflow
);

    localparam int BC_W = cnt_w(N);
    localparam int WC_W = cnt_w(FRAME_LEN);

    state_t          state, state_nxt;
    logic [N-1:0]    window, window_nxt, shifted;
    logic [BC_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [WC_W-1:0] word_cnt, word_cnt_nxt;
    logic            word_done, word_last;
    logic [N:0]      hold_q;
    logic            accept_unused;

    assign shifted = {window[N-2:0], data_in};
    assign locked  = (state == LOCK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= HUNT;
            window   <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            window   <= window_nxt;
            bit_cnt  <= bit_cnt_nxt;
            word_cnt <= word_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        window_nxt   = window;
        bit_cnt_nxt  = bit_cnt;
        word_cnt_nxt = word_cnt;
        word_done    = 1'b0;
        word_last    = 1'b0;
        if (bit_en) begin
            case (state)
                HUNT: begin
                    // Window is never cleared on mismatch so overlapping syncs are found.
                    if (shifted == SYNC_WORD) begin
                        state_nxt    = LOCK;
                        window_nxt   = '0;
                        bit_cnt_nxt  = '0;
                        word_cnt_nxt = '0;
                    end else begin
                        window_nxt = shifted;
                    end
                end
                LOCK: begin
                    window_nxt = shifted;
                    if (bit_cnt == BC_W'(N - 1)) begin
                        word_done   = 1'b1;
                        word_last   = (word_cnt == WC_W'(FRAME_LEN - 1));
                        bit_cnt_nxt = '0;
                        if (word_last) begin
                            state_nxt    = HUNT;
                            window_nxt   = '0;
                            word_cnt_nxt = '0;
                        end else begin
                            word_cnt_nxt = word_cnt + WC_W'(1);
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + BC_W'(1);
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    word_hold_reg #(.W(N + 1)) u_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (word_done),
        .load_data ({shifted, word_last}),
        .out_ready (out_ready),
        .out_data  (hold_q),
        .out_valid (out_valid),
        .accept    (accept_unused),
        .overflow  (overflow)
    );

    assign out_data = hold_q[N:1];
    assign out_last = hold_q[0];

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Randomized bench for sipo_frame_rx against a bit-stream/frame reference model.
module tb_sipo_frame_rx;

    localparam int         N    = 8;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         FL   = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         data_in = 1'b0;
    logic         bit_en = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_data;
    logic         out_valid, out_last, locked, overflow;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit     m_lock;
    int     m_win, m_word, m_bits, m_wcnt;
    bit     m_valid, m_last, m_ovf;
    int     m_data;

    sipo_frame_rx #(.N(N), .SYNC_WORD(SYNC), .FRAME_LEN(FL)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .bit_en    (bit_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .locked    (locked),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_win = 0; m_word = 0; m_bits = 0; m_wcnt = 0;
        m_valid = 0; m_last = 0; m_ovf = 0; m_data = 0;
    endtask

    // Advance the reference by one clock edge given the inputs seen at that edge.
    task automatic model_edge(input bit en, input bit d, input bit rdy);
        bit done, dlast;
        int dval;
        bit fire;
        fire = m_valid && rdy;
        done = 0; dlast = 0; dval = 0;
        if (en) begin
            if (!m_lock) begin
                m_win = ((m_win << 1) | d) & ((1 << N) - 1);
                if (m_win == SYNC) begin
                    m_lock = 1; m_win = 0; m_word = 0; m_bits = 0; m_wcnt = 0;
                end
            end else begin
                m_word = ((m_word << 1) | d) & ((1 << N) - 1);
                m_bits++;
                if (m_bits == N) begin
                    done = 1; dval = m_word; dlast = (m_wcnt == FL - 1);
                    m_bits = 0; m_word = 0; m_wcnt++;
                    if (m_wcnt == FL) begin
                        m_lock = 0; m_win = 0; m_wcnt = 0;
                    end
                end
            end
        end
        m_ovf = done && m_valid && !rdy;
        if (done && (!m_valid || rdy)) begin
            m_valid = 1; m_data = dval; m_last = dlast;
        end else if (fire) begin
            m_valid = 0;
        end
    endtask

    task automatic check_outputs(input string ph);
        chk({ph, ".valid"}, 32'(out_valid), 32'(m_valid));
        chk({ph, ".data"},  32'(out_data),  m_data);
        chk({ph, ".last"},  32'(out_last),  32'(m_last));
        chk({ph, ".locked"}, 32'(locked),   32'(m_lock));
        chk({ph, ".ovf"},   32'(overflow),  32'(m_ovf));
    endtask

    task automatic step(input bit en, input bit d, input bit rdy, input string ph);
        @(negedge clk);
        bit_en = en; data_in = d; out_ready = rdy;
        @(posedge clk);
        #1;
        model_edge(en, d, rdy);
        check_outputs(ph);
    endtask

    // One byte MSB first; optional random idle cycles; ready on the last bit may differ.
    task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit rdy_mid,
                             input bit rdy_last, input string ph);
        logic [7:0] v;
        v = b;
        for (int i = N - 1; i >= 0; i--) begin
            while ($urandom_range(99) < gap_pct) step(1'b0, 1'($urandom), rdy_mid, ph);
            step(1'b1, v[i], (i == 0) ? rdy_last : rdy_mid, ph);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        bit_en = 1'b0;
    endtask

    logic [7:0] basic [5] = '{8'hA5, 8'h3C, 8'h81, 8'hFF, 8'h00};

    initial begin
        model_reset();
        do_reset();

        // basic continuous frame
        foreach (basic[i]) send_byte(basic[i], 0, 1'b1, 1'b1, "basic");
        step(1'b0, 1'b0, 1'b1, "basic");

        // false then overlapping sync, frame follows
        send_byte(8'hA4, 0, 1'b1, 1'b1, "ovl");
        send_byte(8'hA5, 0, 1'b1, 1'b1, "ovl");
        send_byte(8'h12, 0, 1'b1, 1'b1, "ovl");
        for (int i = 0; i < FL - 1; i++) send_byte(8'($urandom), 0, 1'b1, 1'b1, "ovl");

        // backpressure: two words complete with ready low, then drain
        send_byte(SYNC, 0, 1'b0, 1'b0, "bp");
        send_byte(8'h5A, 0, 1'b0, 1'b0, "bp");
        send_byte(8'hC3, 0, 1'b0, 1'b0, "bp");
        step(1'b0, 1'b0, 1'b1, "bp");
        send_byte(8'h77, 0, 1'b1, 1'b1, "bp");
        send_byte(8'h99, 0, 1'b1, 1'b1, "bp");

        // simultaneous consume and load on the completion edge
        send_byte(SYNC, 0, 1'b0, 1'b0, "sim");
        send_byte(8'h11, 0, 1'b0, 1'b0, "sim");
        send_byte(8'h22, 0, 1'b0, 1'b1, "sim");
        send_byte(8'h33, 0, 1'b0, 1'b1, "sim");
        send_byte(8'h44, 0, 1'b0, 1'b1, "sim");
        step(1'b0, 1'b0, 1'b1, "sim");

        // bit_en gaps within frames
        for (int f = 0; f < 3; f++) begin
            send_byte(SYNC, 40, 1'b1, 1'b1, "gap");
            for (int i = 0; i < FL; i++) send_byte(8'($urandom), 40, 1'b1, 1'b1, "gap");
        end

        // reset mid-word with a word held
        send_byte(SYNC, 0, 1'b0, 1'b0, "rst");
        send_byte(8'hE7, 0, 1'b0, 1'b0, "rst");
        step(1'b1, 1'b1, 1'b0, "rst");
        step(1'b1, 1'b0, 1'b0, "rst");
        step(1'b1, 1'b1, 1'b0, "rst");
        do_reset();
        send_byte(SYNC, 0, 1'b1, 1'b1, "post");
        for (int i = 0; i < FL; i++) send_byte(8'(8'h10 + i), 0, 1'b1, 1'b1, "post");

        // random traffic: syncs mixed into random bytes, random ready and gaps
        for (int i = 0; i < 120; i++) begin
            logic [7:0] b;
            b = ($urandom_range(3) == 0) ? SYNC : 8'($urandom);
            send_byte(b, 20, 1'($urandom_range(3) != 0), 1'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sipo_frame_rx.md
Name: sipo_frame_rx

Overview:
- Serial-to-parallel frame receiver, directly downstream of the team's serial shift-register stage; consumes its 1-bit output stream.
- Hunts for a sync word, then assembles a fixed number of N-bit payload words per frame.
- Presents each word on a valid/ready output with a one-entry holding register and an overflow indication.
- Bit order matches the upstream stage: MSB first on the line; each new bit enters at the LSB.

Parameters:
N, 8, payload word width and sync-window width (N >= 2)
SYNC_WORD, 8'hA5, N-bit pattern that opens a frame
FRAME_LEN, 4, payload words per frame after sync (>= 1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  1  serial bit from upstream stage
bit_en  input  1  data_in is a valid bit this cycle; ignored when low
out_data  output  N  assembled word; first-received bit at MSB
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer accepts word when out_valid && out_ready
out_last  output  1  qualifies out_data as final word of the frame
locked  output  1  high while in LOCK state
overflow  output  1  one-cycle pulse: completed word dropped, holding register occupied

Behaviour:
- Reset (async, any time, including mid-word or mid-frame):
  - state=HUNT; window, bit_cnt, word_cnt = 0.
  - out_data=0, out_valid=0, out_last=0, locked=0, overflow=0.
  - Any partial word or held word is discarded.
- States: HUNT, LOCK. locked = (state==LOCK), registered.
- bit_en low: no counter, window or state change. Output handshake still operates.
- HUNT, bit_en=1:
  - nxt = {window[N-2:0], data_in}.
  - nxt==SYNC_WORD: state<=LOCK, window<=0, bit_cnt<=0, word_cnt<=0.
  - Otherwise: window<=nxt.
  - Overlapping patterns are detected; the window is never cleared on mismatch.
- LOCK, bit_en=1:
  - Shift data_in into the window; bit_cnt increments.
  - On the Nth bit (bit_cnt==N-1), the word completes with value {window[N-2:0], data_in}.
  - bit_cnt<=0; word_cnt increments.
  - If word_cnt==FRAME_LEN-1: state<=HUNT, window<=0, word_cnt<=0.
- Word completion latency:
  - Last bit sampled at edge k; out_valid, out_data and out_last are visible after edge k.
  - out_last=1 only for the word completed with word_cnt==FRAME_LEN-1.
- Holding register (single entry):
  - Handshake fires when out_valid && out_ready at an edge; that edge clears out_valid unless a new word loads the same edge.
  - Word completes while the register is empty, or fires in the same edge: load it, out_valid=1. No overflow (simultaneous consume+load is lossless).
  - Word completes while out_valid=1 and out_ready=0: new word dropped, held word unchanged, overflow=1 for one cycle.
  - In the overflow case, counters and state still advance; the frame continues.
- out_data and out_last hold stable while out_valid && !out_ready.
- Back-to-back frames: sync search restarts on the first bit_en after the last payload bit. No sync word is needed between payload bits.
- Widths: bit_cnt is $clog2(N) bits; word_cnt is $clog2(FRAME_LEN) bits, minimum 1. Neither counter exceeds its terminal value.

Decomposition:
- Shared package sipo_frame_pkg holds:
  - state typedef (HUNT, LOCK);
  - default constants for N, SYNC_WORD, FRAME_LEN;
  - count-width helper function.
- One natural sub-module: word_hold_reg (parameter N+1 bits for data+last).
  - Contains the valid/ready holding register.
  - Has load input, accept output and overflow pulse.
  - Top level keeps the FSM, window and counters.

Test Plan:
- Basic frame: bit_en=1 continuous, bits 0xA5 then 0x3C, 0x81, 0xFF, 0x00 MSB-first, out_ready=1 -> four out_valid beats with those values; out_last only on 0x00; locked high from edge after sync, low after the 40th bit; overflow never set.
- False/overlapping sync: stream 0xA4, 0xA5, 0x12, … -> no lock during 0xA4; lock exactly when the last bit of 0xA5 is sampled; first word = 0x12.
- Backpressure: out_ready=0 across two completed words -> first word held stable, one-cycle overflow pulse at second completion. out_ready=1 later -> first word accepted; following words flow normally.
- Simultaneous: out_ready rises on the exact edge the next word completes -> old word accepted, new word loaded, out_valid stays 1, no overflow.
- bit_en gaps: random idle cycles between bits of a frame -> identical words, order and out_last as the continuous case.
- Reset mid-operation: assert reset after 3 bits of word 2 with a word held -> immediately out_valid=0, locked=0, overflow=0. A fresh sync+frame after release is received correctly.
